// File: rtl/r2mdc_stage_ctrl.sv
// r2mdc_stage_ctrl: delay-line and commutator sequencing for one radix-2 MDC FFT stage
module r2mdc_stage_ctrl #(
  parameter int DELAY_CYCLES = 16,
  parameter int NUM_INPUTS_PER_PATH = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       in_valid,
  output logic [4:0] pair_cnt,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic       rd_en,
  output logic [4:0] rd_addr,
  output logic       cm_swap,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);
  localparam logic [4:0] DL = 5'(DELAY_CYCLES - 1);
  localparam logic [4:0] NL = 5'(NUM_INPUTS_PER_PATH - 1);
  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0] wr_cnt, rd_cnt, swp_cnt;
  assign wr_en = in_valid && (state == FILL || state == RUN);
  assign rd_en = (state == RUN && in_valid) || state == DRAIN;
  assign wr_addr = wr_cnt;
  assign pair_cnt = wr_cnt;
  assign rd_addr = rd_cnt;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FILL : IDLE;
      FILL:    if (wr_en && wr_cnt == DL) state_nxt = (DELAY_CYCLES == NUM_INPUTS_PER_PATH) ? DRAIN : RUN;
      RUN:     if (wr_en && wr_cnt == NL) state_nxt = DRAIN;
      DRAIN:   if (rd_cnt == NL) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // counters saturate at N-1 so the terminal index is held, never wrapped, within a frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      swp_cnt <= '0;
      cm_swap <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      out_valid <= rd_en;
      if (state == IDLE && start) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
        swp_cnt <= '0;
        cm_swap <= 1'b0;
      end
      if (wr_en && wr_cnt != NL) wr_cnt <= wr_cnt + 5'd1;
      if (rd_en) begin
        if (rd_cnt != NL) rd_cnt <= rd_cnt + 5'd1;
        swp_cnt <= (swp_cnt == DL) ? '0 : swp_cnt + 5'd1;
        if (swp_cnt == DL) cm_swap <= ~cm_swap;
      end
    end
  end
endmodule
